inex_recur_expand: RTL and testbench

Expansion stage directly downstream of `get_param` in the inexact-search engine. Accepts one (i, z, k, l) search-state tuple, reads the query symbol and occurrence counts, and computes the child intervals for the four bases (plus an optional insertion branch). It pushes surviving children back onto the InexRecur stack regfile as 32-bit words and emits a result when a tuple has consumed the whole query.

---
 rtl/inex_recur_expand_pkg.sv | 82 ++++++++
 rtl/inex_recur_expand_child_calc.sv | 37 +++
 rtl/inex_recur_expand.sv | 227 ++++++++++++++++++++++
 tb/tb_inex_recur_expand.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inex_recur_expand_pkg.sv
// -----------------------------------------------------------------------------
// inex_recur_expand_pkg
// Shared definitions for the InexRecur expansion stage: base codes, the
// C-table (cumulative symbol counts), FSM state encodings and the layout of
// the 32-bit stack word {i, z, k, l}.
// Optional feature macro used by the importing RTL: INEX_INS_EN.
// -----------------------------------------------------------------------------
package inex_recur_expand_pkg;

    // Width of every tuple field (i, z, k, l) and of an O-table entry
    localparam int FIELD_W = 8;

    // Base codes
    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    // C-table: number of reference symbols lexically smaller than each base
    localparam logic [8:0] C_A = 9'd0;
    localparam logic [8:0] C_C = 9'd10;
    localparam logic [8:0] C_G = 9'd20;
    localparam logic [8:0] C_T = 9'd30;

    // Field positions inside the packed stack word
    localparam int WORD_I_LSB = 24;
    localparam int WORD_Z_LSB = 16;
    localparam int WORD_K_LSB = 8;
    localparam int WORD_L_LSB = 0;

    // Expansion FSM states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_RESULT = 4'd2,
        ST_INS    = 4'd3,
        ST_OCC_K  = 4'd4,
        ST_OCC_L  = 4'd5,
        ST_CALC   = 4'd6,
        ST_PUSH   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    // C-table lookup, returned at 9 bits so child bounds never wrap
    function automatic logic [8:0] c_of(input logic [1:0] b);
        logic [8:0] c;
        case (b)
            BASE_A:  c = C_A;
            BASE_C:  c = C_C;
            BASE_G:  c = C_G;
            BASE_T:  c = C_T;
            default: c = C_A;
        endcase
        return c;
    endfunction

    // Assemble one stack word from its four fields
    function automatic logic [31:0] pack_word(
        input logic [FIELD_W-1:0] i,
        input logic [FIELD_W-1:0] z,
        input logic [FIELD_W-1:0] k,
        input logic [FIELD_W-1:0] l
    );
        return (32'(i) << WORD_I_LSB) |
               (32'(z) << WORD_Z_LSB) |
               (32'(k) << WORD_K_LSB) |
               (32'(l) << WORD_L_LSB);
    endfunction

    // First base to expand for a given resume position (0 and 1 both start at A)
    function automatic logic [1:0] start_base(input logic [3:0] pos);
        logic [1:0] b;
        case (pos)
            4'd2:    b = BASE_C;
            4'd3:    b = BASE_G;
            4'd4:    b = BASE_T;
            default: b = BASE_A;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/inex_recur_expand_child_calc.sv
// -----------------------------------------------------------------------------
// inex_child_calc
// Combinational child-interval computation for one base b:
//   k' = C[b] + O(b, k-1) + 1,  l' = C[b] + O(b, l)   (9-bit arithmetic)
//   z' = z on a match, z-1 on a substitution
//   keep when the interval is non-empty, fits in 8 bits and the edit is legal.
// -----------------------------------------------------------------------------
module inex_child_calc
    import inex_recur_expand_pkg::*;
(
    input  logic [1:0]         b,
    input  logic [FIELD_W-1:0] o_k,
    input  logic [FIELD_W-1:0] o_l,
    input  logic [FIELD_W-1:0] z,
    input  logic [1:0]         sym,
    output logic [FIELD_W-1:0] k_new,
    output logic [FIELD_W-1:0] l_new,
    output logic [FIELD_W-1:0] z_new,
    output logic               keep
);

    logic [8:0] k_sum;
    logic [8:0] l_sum;
    logic       is_match;

    // Interval bounds, edit budget and survival test for the candidate child
    always_comb begin
        is_match = (b == sym);
        k_sum    = c_of(b) + {1'b0, o_k} + 9'd1;
        l_sum    = c_of(b) + {1'b0, o_l};
        z_new    = is_match ? z : (z - 8'd1);
        keep     = (k_sum <= l_sum) && !l_sum[8] && (is_match || (z != 8'd0));
        k_new    = k_sum[FIELD_W-1:0];
        l_new    = l_sum[FIELD_W-1:0];
    end

endmodule

// File: rtl/inex_recur_expand.sv
// -----------------------------------------------------------------------------
// inex_recur_expand
// Expansion stage behind get_param in the inexact-search engine. Takes one
// (i, z, k, l) tuple, walks the bases A..T starting at the resume position,
// fetches O(b, k-1) and O(b, l) from the occurrence table and pushes every
// surviving child back onto the InexRecur stack. A tuple with i == 0 has
// consumed the query and is reported on the result port instead.
//
// Build option: define INEX_INS_EN to add the insertion branch, which pushes
// {i-1, z-1, k, l} ahead of the base children for fresh tuples with z > 0.
// -----------------------------------------------------------------------------
module inex_recur_expand
#(
    parameter int STACK_AW = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                param_valid,
    output logic                param_ready,
    input  logic [7:0]          i_in,
    input  logic [7:0]          z_in,
    input  logic [7:0]          k_in,
    input  logic [7:0]          l_in,
    input  logic [STACK_AW-1:0] addr_in,
    input  logic [3:0]          position_in,
    output logic [7:0]          qry_idx,
    input  logic [1:0]          qry_sym,
    output logic                occ_req,
    output logic [1:0]          occ_base,
    output logic [7:0]          occ_idx,
    input  logic [7:0]          occ_rdata,
    output logic                push_en,
    output logic [31:0]         push_data,
    input  logic                stack_full,
    output logic                res_valid,
    output logic [7:0]          res_k,
    output logic [7:0]          res_l,
    input  logic                res_ready,
    output logic                busy
);

    import inex_recur_expand_pkg::*;

    state_t              state;

    // Latched tuple
    logic [FIELD_W-1:0]  i_r;
    logic [FIELD_W-1:0]  z_r;
    logic [FIELD_W-1:0]  k_r;
    logic [FIELD_W-1:0]  l_r;
    logic [STACK_AW-1:0] addr_r;
    logic [3:0]          pos_r;

    // Base currently being expanded and the captured O(b, k-1)
    logic [1:0]          b_r;
    logic [FIELD_W-1:0]  ok_r;

    // Child candidate from the calculator
    logic [FIELD_W-1:0]  child_k;
    logic [FIELD_W-1:0]  child_l;
    logic [FIELD_W-1:0]  child_z;
    logic                child_keep;

    // Stack address is carried only for debug visibility
    logic                unused_addr_dbg;

    assign unused_addr_dbg = ^addr_r;

    assign param_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign qry_idx     = i_r - 8'd1;

    // A push is offered only while the stack has room; the insertion push
    // exists only for tuples that still have an edit to spend
    assign push_en = !stack_full &&
                     ((state == ST_PUSH) || ((state == ST_INS) && (z_r != 8'd0)));

    inex_child_calc u_child_calc (
        .b     (b_r),
        .o_k   (ok_r),
        .o_l   (occ_rdata),
        .z     (z_r),
        .sym   (qry_sym),
        .k_new (child_k),
        .l_new (child_l),
        .z_new (child_z),
        .keep  (child_keep)
    );

    // Expansion FSM with registered occ-request, push word and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            i_r       <= '0;
            z_r       <= '0;
            k_r       <= '0;
            l_r       <= '0;
            addr_r    <= '0;
            pos_r     <= '0;
            b_r       <= '0;
            ok_r      <= '0;
            occ_req   <= 1'b0;
            occ_base  <= '0;
            occ_idx   <= '0;
            push_data <= '0;
            res_valid <= 1'b0;
            res_k     <= '0;
            res_l     <= '0;
        end else begin
            occ_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (param_valid) begin
                        i_r    <= i_in;
                        z_r    <= z_in;
                        k_r    <= k_in;
                        l_r    <= l_in;
                        addr_r <= addr_in;
                        pos_r  <= position_in;
                        state  <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (pos_r >= 4'd5) begin
                        state <= ST_DONE;
                    end else if (i_r == 8'd0) begin
                        res_valid <= 1'b1;
                        res_k     <= k_r;
                        res_l     <= l_r;
                        state     <= ST_RESULT;
                    end else begin
                        b_r <= start_base(pos_r);
`ifdef INEX_INS_EN
                        if (pos_r == 4'd0) begin
                            push_data <= pack_word(i_r - 8'd1, z_r - 8'd1, k_r, l_r);
                            state     <= ST_INS;
                        end else begin
                            occ_req  <= (k_r != 8'd0);
                            occ_base <= start_base(pos_r);
                            occ_idx  <= k_r - 8'd1;
                            state    <= ST_OCC_K;
                        end
`else
                        occ_req  <= (k_r != 8'd0);
                        occ_base <= start_base(pos_r);
                        occ_idx  <= k_r - 8'd1;
                        state    <= ST_OCC_K;
`endif
                    end
                end

                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_DONE;
                    end
                end

`ifdef INEX_INS_EN
                ST_INS: begin
                    // Wait only if there is an insertion child to deliver
                    if (!((z_r != 8'd0) && stack_full)) begin
                        occ_req  <= (k_r != 8'd0);
                        occ_base <= b_r;
                        occ_idx  <= k_r - 8'd1;
                        state    <= ST_OCC_K;
                    end
                end
`endif

                ST_OCC_K: begin
                    // k-side read (if any) is in flight; issue the l-side read
                    occ_req  <= 1'b1;
                    occ_base <= b_r;
                    occ_idx  <= l_r;
                    state    <= ST_OCC_L;
                end

                ST_OCC_L: begin
                    // With k == 0 no request was made, so O(b, -1) is zero
                    ok_r  <= (k_r == 8'd0) ? 8'd0 : occ_rdata;
                    state <= ST_CALC;
                end

                ST_CALC: begin
                    if (child_keep) begin
                        push_data <= pack_word(i_r - 8'd1, child_z, child_k, child_l);
                        state     <= ST_PUSH;
                    end else if (b_r != BASE_T) begin
                        b_r      <= b_r + 2'd1;
                        occ_req  <= (k_r != 8'd0);
                        occ_base <= b_r + 2'd1;
                        occ_idx  <= k_r - 8'd1;
                        state    <= ST_OCC_K;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                ST_PUSH: begin
                    // Word stays on push_data until the stack takes it
                    if (!stack_full) begin
                        if (b_r != BASE_T) begin
                            b_r      <= b_r + 2'd1;
                            occ_req  <= (k_r != 8'd0);
                            occ_base <= b_r + 2'd1;
                            occ_idx  <= k_r - 8'd1;
                            state    <= ST_OCC_K;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inex_recur_expand.sv
// -----------------------------------------------------------------------------
// tb_inex_recur_expand
// Directed bench for inex_recur_expand. An occurrence-table model answers
// every occ_req one cycle later; a monitor records pushed words and counts
// occ requests. Expected words and cycle counts are hand-computed.
// -----------------------------------------------------------------------------
module tb_inex_recur_expand;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        param_valid = 1'b0;
    logic        param_ready;
    logic [7:0]  i_in = 8'd0;
    logic [7:0]  z_in = 8'd0;
    logic [7:0]  k_in = 8'd0;
    logic [7:0]  l_in = 8'd0;
    logic [11:0] addr_in = 12'd0;
    logic [3:0]  position_in = 4'd0;
    logic [7:0]  qry_idx;
    logic [1:0]  qry_sym = 2'd0;
    logic        occ_req;
    logic [1:0]  occ_base;
    logic [7:0]  occ_idx;
    logic [7:0]  occ_rdata = 8'd0;
    logic        push_en;
    logic [31:0] push_data;
    logic        stack_full = 1'b0;
    logic        res_valid;
    logic [7:0]  res_k;
    logic [7:0]  res_l;
    logic        res_ready = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int o_mode = 0;
    int occ_cnt = 0;
    logic [31:0] push_q[$];

    inex_recur_expand #(.STACK_AW(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .param_valid(param_valid),
        .param_ready(param_ready),
        .i_in       (i_in),
        .z_in       (z_in),
        .k_in       (k_in),
        .l_in       (l_in),
        .addr_in    (addr_in),
        .position_in(position_in),
        .qry_idx    (qry_idx),
        .qry_sym    (qry_sym),
        .occ_req    (occ_req),
        .occ_base   (occ_base),
        .occ_idx    (occ_idx),
        .occ_rdata  (occ_rdata),
        .push_en    (push_en),
        .push_data  (push_data),
        .stack_full (stack_full),
        .res_valid  (res_valid),
        .res_k      (res_k),
        .res_l      (res_l),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Occurrence table: mode 0 -> every O = 2; mode 1 -> O(b,8) = 3, else 0
    function automatic logic [7:0] occ_model(input int mode, input logic [7:0] idx);
        if (mode == 0) return 8'd2;
        return (idx == 8'd8) ? 8'd3 : 8'd0;
    endfunction

    always @(posedge clk) begin
        if (occ_req) occ_rdata <= occ_model(o_mode, occ_idx);
    end

    always @(negedge clk) begin
        if (push_en) push_q.push_back(push_data);
        if (occ_req) occ_cnt++;
    end

    task automatic clear_mon();
        push_q.delete();
        occ_cnt = 0;
    endtask

    // Present a tuple; returns the cycle stamp of the accepting edge
    task automatic send_tuple(input logic [7:0] i, input logic [7:0] z,
                              input logic [7:0] k, input logic [7:0] l,
                              input logic [3:0] pos, output int t0);
        i_in = i; z_in = z; k_in = k; l_in = l; position_in = pos;
        addr_in = 12'h5A5;
        param_valid = 1'b1;
        @(posedge clk); #1;
        param_valid = 1'b0;
        t0 = cyc;
    endtask

    // Cycles from the accept edge (counted as 1) until busy drops; -1 on timeout
    task automatic wait_idle(input int t0, output int ncyc);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ncyc = busy ? -1 : (cyc - t0 + 1);
    endtask

    function automatic logic [31:0] got_word(input int idx);
        return (idx < push_q.size()) ? push_q[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic test_reset();
        #1;
        tests++; if (param_ready !== 1'b1) begin fails++; $display("FAIL reset_param_ready: got %b want 1", param_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (occ_req !== 1'b0) begin fails++; $display("FAIL reset_occ_req: got %b want 0", occ_req); end
        tests++; if (push_en !== 1'b0) begin fails++; $display("FAIL reset_push_en: got %b want 0", push_en); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        tests++; if (push_data !== 32'd0) begin fails++; $display("FAIL reset_push_data: got %h want 0", push_data); end
        tests++; if ({occ_base, occ_idx, res_k, res_l} !== 26'd0) begin fails++; $display("FAIL reset_fields: got %h want 0", {occ_base, occ_idx, res_k, res_l}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0 || param_ready !== 1'b1) begin fails++; $display("FAIL reset_release_idle: got busy=%b ready=%b want 0/1", busy, param_ready); end
    endtask

    // (3,0,1,8), sym 2, all O = 2: every child has k' > l', nothing pushed
    task automatic test_no_survivors();
        int t0, n;
        clear_mon();
        o_mode = 0; qry_sym = 2'd2;
        send_tuple(8'd3, 8'd0, 8'd1, 8'd8, 4'd0, t0);
        tests++; if (qry_idx !== 8'd2) begin fails++; $display("FAIL nosurv_qry_idx: got %0d want 2", qry_idx); end
        wait_idle(t0, n);
        tests++; if (n !== 15) begin fails++; $display("FAIL nosurv_cycles: got %0d want 15", n); end
        tests++; if (push_q.size() !== 0) begin fails++; $display("FAIL nosurv_pushes: got %0d want 0", push_q.size()); end
        tests++; if (occ_cnt !== 8) begin fails++; $display("FAIL nosurv_occ_reqs: got %0d want 8", occ_cnt); end
    endtask

    // (3,1,1,8), sym 1, O(b,0)=0, O(b,8)=3: four children in base order
    task automatic test_full_expand();
        int t0, n;
        logic [31:0] exp_q[$];
        int exp_cyc;
        clear_mon();
        o_mode = 1; qry_sym = 2'd1;
        exp_q.delete();
        exp_cyc = 19;
`ifdef INEX_INS_EN
        exp_q.push_back(32'h02000108);
        exp_cyc = 20;
`endif
        exp_q.push_back(32'h02000103);
        exp_q.push_back(32'h02010B0D);
        exp_q.push_back(32'h02001517);
        exp_q.push_back(32'h02001F21);
        send_tuple(8'd3, 8'd1, 8'd1, 8'd8, 4'd0, t0);
        wait_idle(t0, n);
        tests++; if (n !== exp_cyc) begin fails++; $display("FAIL full_cycles: got %0d want %0d", n, exp_cyc); end
        tests++; if (push_q.size() !== exp_q.size()) begin fails++; $display("FAIL full_push_count: got %0d want %0d", push_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            tests++;
            if (got_word(j) !== exp_q[j]) begin fails++; $display("FAIL full_push_word%0d: got %h want %h", j, got_word(j), exp_q[j]); end
        end
    endtask

    // i = 0: result held while the consumer stalls
    task automatic test_result_hold();
        int t0, n;
        clear_mon();
        res_ready = 1'b0;
        send_tuple(8'd0, 8'd2, 8'd5, 8'd9, 4'd0, t0);
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (res_valid !== 1'b1 || res_k !== 8'd5 || res_l !== 8'd9) begin
                fails++; $display("FAIL result_hold%0d: got v=%b k=%0d l=%0d want 1/5/9", j, res_valid, res_k, res_l);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL result_drop: got %b want 0", res_valid); end
        wait_idle(t0, n);
        tests++; if (push_q.size() !== 0 || occ_cnt !== 0) begin fails++; $display("FAIL result_no_push: got %0d pushes %0d reqs want 0/0", push_q.size(), occ_cnt); end
    endtask

    // position_in = 7: straight to DONE
    task automatic test_skip_position();
        int t0, n;
        clear_mon();
        send_tuple(8'd3, 8'd1, 8'd1, 8'd8, 4'd7, t0);
        wait_idle(t0, n);
        tests++; if (n !== 3) begin fails++; $display("FAIL skip_cycles: got %0d want 3", n); end
        tests++; if (param_ready !== 1'b1) begin fails++; $display("FAIL skip_ready: got %b want 1", param_ready); end
        tests++; if (occ_cnt !== 0 || push_q.size() !== 0) begin fails++; $display("FAIL skip_activity: got %0d reqs %0d pushes want 0/0", occ_cnt, push_q.size()); end
    endtask

    // Stack full for 4 cycles while the second child waits
    task automatic test_stall();
        int t0, n, guard;
        logic [31:0] held;
        clear_mon();
        o_mode = 1; qry_sym = 2'd1;
        send_tuple(8'd3, 8'd1, 8'd1, 8'd8, 4'd1, t0);
        guard = 0;
        while (push_q.size() < 1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++; if (push_q.size() !== 1) begin fails++; $display("FAIL stall_first_push: got %0d want 1", push_q.size()); end
        stack_full = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        held = push_data;
        tests++; if (held !== 32'h02010B0D) begin fails++; $display("FAIL stall_held_word: got %h want 02010b0d", held); end
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (push_en !== 1'b0 || push_data !== 32'h02010B0D || busy !== 1'b1) begin
                fails++; $display("FAIL stall_hold%0d: got en=%b data=%h want 0/02010b0d", j, push_en, push_data);
            end
            @(posedge clk); #1;
        end
        stack_full = 1'b0;
        wait_idle(t0, n);
        tests++; if (n !== 23) begin fails++; $display("FAIL stall_cycles: got %0d want 23", n); end
        tests++; if (push_q.size() !== 4) begin fails++; $display("FAIL stall_push_count: got %0d want 4", push_q.size()); end
        tests++; if (got_word(1) !== 32'h02010B0D || got_word(3) !== 32'h02001F21) begin
            fails++; $display("FAIL stall_words: got %h %h want 02010b0d 02001f21", got_word(1), got_word(3));
        end
    endtask

    // Asynchronous reset during OCC_L, then a clean rerun
    task automatic test_reset_midrun();
        int t0, n;
        clear_mon();
        o_mode = 1; qry_sym = 2'd1;
        send_tuple(8'd3, 8'd1, 8'd1, 8'd8, 4'd0, t0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (occ_req !== 1'b1 || occ_idx !== 8'd8) begin fails++; $display("FAIL midrst_occ_l: got req=%b idx=%0d want 1/8", occ_req, occ_idx); end
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || param_ready !== 1'b1) begin fails++; $display("FAIL midrst_state: got busy=%b ready=%b want 0/1", busy, param_ready); end
        tests++; if (occ_req !== 1'b0 || push_en !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL midrst_strobes: got %b%b%b want 000", occ_req, push_en, res_valid); end
        tests++; if ({occ_base, occ_idx, push_data, res_k, res_l} !== 58'd0) begin fails++; $display("FAIL midrst_fields: got %h want 0", {occ_base, occ_idx, push_data, res_k, res_l}); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        send_tuple(8'd3, 8'd1, 8'd1, 8'd8, 4'd1, t0);
        wait_idle(t0, n);
        tests++; if (n !== 19) begin fails++; $display("FAIL midrst_rerun_cycles: got %0d want 19", n); end
        tests++; if (push_q.size() !== 4 || got_word(0) !== 32'h02000103 || got_word(2) !== 32'h02001517) begin
            fails++; $display("FAIL midrst_rerun_words: got n=%0d %h %h want 4 02000103 02001517", push_q.size(), got_word(0), got_word(2));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_no_survivors();
        test_full_expand();
        test_result_hold();
        test_skip_position();
        test_stall();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute safety bound on run time
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
